pcie_phy_tx_sym_sched: RTL and testbench

- Per-symbol transmit scheduler that sits directly upstream of the 8b/10b encoder (pcie_phy_8b10b) and sequences everything the encoder sees.
- Arbitrates between two requester streams: ordered sets from the LTSSM, and TLP/DLLP link data.
- Inserts SKP ordered sets periodically, emits logical idle (D0.0) when no requester is active, and sequences entry into and exit from electrical idle through EIOS.
- Produces one symbol per clk: an 8-bit value plus a D/K# flag, the encoder's address format.

---
 rtl/pcie_phy_pkg.sv | 32 +++
 rtl/pcie_phy_skp_timer.sv | 51 +++++
 rtl/pcie_phy_tx_sym_sched.sv | 127 ++++++++++++
 tb/tb_pcie_phy_tx_sym_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY symbol constants and the transmit scheduler state type,
// used by both the transmit scheduler and the receive-side decoder.
package pcie_phy_pkg;

  localparam logic [7:0] COM  = 8'hBC;  // K28.5
  localparam logic [7:0] SKP  = 8'h1C;  // K28.0
  localparam logic [7:0] IDL  = 8'h7C;  // K28.3
  localparam logic [7:0] D0_0 = 8'h00;

  typedef enum logic [2:0] {
    ST_EIDLE,
    ST_ACTIVE_IDLE,
    ST_OS,
    ST_LD,
    ST_SKP,
    ST_EIOS
  } tx_sched_state_t;

  function automatic tx_sched_state_t boundary_next(input logic eidle_req,
                                                    input logic skp_req,
                                                    input logic os_req,
                                                    input logic ld_req);
    tx_sched_state_t nxt;
    if (eidle_req)    nxt = ST_EIOS;
    else if (skp_req) nxt = ST_SKP;
    else if (os_req)  nxt = ST_OS;
    else if (ld_req)  nxt = ST_LD;
    else              nxt = ST_ACTIVE_IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/pcie_phy_skp_timer.sv
// SKP interval timer: counts symbol clocks and holds a saturating
// SKP request until the scheduler launches the SKP COM.
module pcie_phy_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 11
) (
  input  logic clk,
  input  logic rst_i,
  input  logic freeze_i,
  input  logic clear_i,
  input  logic force_i,
  input  logic consume_i,
  output logic skp_req_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             expire;

  always_comb begin
    expire = !freeze_i && !clear_i && (cnt_q == LAST_CNT);
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (clear_i) begin
      cnt_d  = '0;
      pend_d = force_i;
    end else if (!freeze_i) begin
      cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
      // A fresh expiry wins over a same-cycle launch so no interval is lost.
      if (expire)         pend_d = 1'b1;
      else if (consume_i) pend_d = 1'b0;
    end
  end

  // Expiry is visible immediately so a boundary in the expiry cycle
  // already schedules the SKP.
  assign skp_req_o = pend_q | expire;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/pcie_phy_tx_sym_sched.sv
// Per-symbol transmit scheduler feeding the 8b/10b encoder: arbitrates
// ordered sets and link data, inserts SKP, idles, and sequences EIOS/EIDLE.
module pcie_phy_tx_sym_sched
  import pcie_phy_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       os_valid_i,
  input  logic [7:0] os_sym_i,
  input  logic       os_dk_n_i,
  input  logic       os_last_i,
  output logic       os_ready_o,
  input  logic       ld_valid_i,
  input  logic [7:0] ld_sym_i,
  input  logic       ld_dk_n_i,
  input  logic       ld_last_i,
  output logic       ld_ready_o,
  input  logic       eidle_req_i,
  output logic [7:0] sym_out_o,
  output logic       sym_dk_n_o,
  output logic       eidle_out_o,
  output logic       skp_sent_o
);

  tx_sched_state_t state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      sym_q, sym_d;
  logic            dk_q, dk_d;
  logic            eidle_q, eidle_d;
  logic            skp_sent_q, skp_sent_d;
  logic            skp_req;

  pcie_phy_skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_W       (CNT_W)
  ) u_skp_timer (
    .clk      (clk),
    .rst_i    (rst_i),
    .freeze_i (state_q == ST_EIOS),
    .clear_i  (state_q == ST_EIDLE),
    .force_i  ((state_q == ST_EIDLE) && !eidle_req_i),
    .consume_i((state_q == ST_SKP) && (idx_q == 2'd0)),
    .skp_req_o(skp_req)
  );

  // Acceptance happens only once a stream is locked, so ready is pure state.
  assign os_ready_o = (state_q == ST_OS);
  assign ld_ready_o = (state_q == ST_LD);

  // NOTE: every combinational output gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = '0;
    sym_d      = D0_0;
    dk_d       = 1'b1;
    eidle_d    = 1'b0;
    skp_sent_d = 1'b0;
    case (state_q)
      ST_EIDLE: begin
        eidle_d = 1'b1;
        if (!eidle_req_i) state_d = ST_ACTIVE_IDLE;
      end
      ST_ACTIVE_IDLE: begin
        state_d = boundary_next(eidle_req_i, skp_req, os_valid_i, ld_valid_i);
      end
      ST_OS: begin
        if (os_valid_i) begin
          sym_d = os_sym_i;
          dk_d  = os_dk_n_i;
          // The finishing stream's own valid still flags this last symbol.
          if (os_last_i) state_d = boundary_next(eidle_req_i, skp_req, 1'b0, ld_valid_i);
        end
      end
      ST_LD: begin
        if (ld_valid_i) begin
          sym_d = ld_sym_i;
          dk_d  = ld_dk_n_i;
          if (ld_last_i) state_d = boundary_next(eidle_req_i, skp_req, os_valid_i, 1'b0);
        end
      end
      ST_SKP: begin
        sym_d      = (idx_q == 2'd0) ? COM : SKP;
        dk_d       = 1'b0;
        skp_sent_d = (idx_q == 2'd0);
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = boundary_next(eidle_req_i, skp_req, os_valid_i, ld_valid_i);
      end
      ST_EIOS: begin
        sym_d = (idx_q == 2'd0) ? COM : IDL;
        dk_d  = 1'b0;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_EIDLE;
      end
      default: state_d = ST_EIDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= ST_EIDLE;
      idx_q      <= '0;
      sym_q      <= D0_0;
      dk_q       <= 1'b1;
      eidle_q    <= 1'b1;
      skp_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      dk_q       <= dk_d;
      eidle_q    <= eidle_d;
      skp_sent_q <= skp_sent_d;
    end
  end

  assign sym_out_o   = sym_q;
  assign sym_dk_n_o  = dk_q;
  assign eidle_out_o = eidle_q;
  assign skp_sent_o  = skp_sent_q;

endmodule

// File: tb/tb_pcie_phy_tx_sym_sched.sv
// Scoreboard bench for pcie_phy_tx_sym_sched with a 16-symbol SKP interval;
// stimulus queues hand-derived per-cycle outputs, a monitor compares them.
module tb_pcie_phy_tx_sym_sched;

  localparam int SKP_INTERVAL = 16;
  localparam int CNT_W        = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_valid, os_dk_n, os_last, os_ready;
  logic [7:0] os_sym;
  logic       ld_valid, ld_dk_n, ld_last, ld_ready;
  logic [7:0] ld_sym;
  logic       eidle_req;
  logic [7:0] sym_out;
  logic       sym_dk_n, eidle_out, skp_sent;

  always #5 clk = ~clk;

  pcie_phy_tx_sym_sched #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_i      (rst),
    .os_valid_i (os_valid),
    .os_sym_i   (os_sym),
    .os_dk_n_i  (os_dk_n),
    .os_last_i  (os_last),
    .os_ready_o (os_ready),
    .ld_valid_i (ld_valid),
    .ld_sym_i   (ld_sym),
    .ld_dk_n_i  (ld_dk_n),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .eidle_req_i(eidle_req),
    .sym_out_o  (sym_out),
    .sym_dk_n_o (sym_dk_n),
    .eidle_out_o(eidle_out),
    .skp_sent_o (skp_sent)
  );

  // Packed as {os_ready, ld_ready, skp_sent, eidle_out, dk_n, sym}.
  typedef struct {
    logic [12:0] v;
    int          scen;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   scen   = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h ({osr,ldr,skp,eid,dk,sym})", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check($sformatf("s%0d_c%0d", x.scen, x.cyc),
              {19'b0, os_ready, ld_ready, skp_sent, eidle_out, sym_dk_n, sym_out},
              {19'b0, x.v});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [7:0] s, input logic d, input logic e,
                      input logic k, input logic o, input logic l);
    exp_t x;
    x.v    = {o, l, k, e, d, s};
    x.scen = scen;
    x.cyc  = cyc;
    sb.push_back(x);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic step_p(input logic [8:0] p, input logic o, input logic l);
    step(p[7:0], p[8], 1'b0, 1'b0, o, l);
  endtask

  task automatic os_idle();
    os_valid = 1'b0; os_sym = 8'h00; os_dk_n = 1'b1; os_last = 1'b0;
  endtask

  task automatic ld_idle();
    ld_valid = 1'b0; ld_sym = 8'h00; ld_dk_n = 1'b1; ld_last = 1'b0;
  endtask

  task automatic drv_os(input logic [8:0] p, input logic last);
    os_valid = 1'b1; {os_dk_n, os_sym} = p; os_last = last;
  endtask

  task automatic drv_ld(input logic [8:0] p, input logic last);
    ld_valid = 1'b1; {ld_dk_n, ld_sym} = p; ld_last = last;
  endtask

  // Packet symbol i of n: STP first, END last, data in between.
  function automatic logic [8:0] pk(input int i, input int n, input logic [7:0] base);
    if (i == 0)     return {1'b0, 8'hFB};
    if (i == n - 1) return {1'b0, 8'hFD};
    return {1'b1, base + 8'(i)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    os_idle();
    ld_idle();
    eidle_req = 1'b0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset release, one EIDLE output cycle, D0_0, then the forced SKP.
  task automatic prefix();
    do_reset();
    step(8'h00, 1, 1, 0, 0, 0);                // c0 reset values
    step(8'h00, 1, 1, 0, 0, 0);                // c1
    step(8'h00, 1, 0, 0, 0, 0);                // c2
    step(8'hBC, 0, 0, 1, 0, 0);                // c3
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);     // c4..c6
  endtask

  initial begin
    // 1: idle exit and periodic SKP from idle
    scen = 1;
    prefix();
    repeat (11) step(8'h00, 1, 0, 0, 0, 0);    // c7..c17
    step(8'hBC, 0, 0, 1, 0, 0);                // c18
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 0, 0);                // c22

    // 2: 20-symbol packet spans an expiry; SKP right after END
    scen = 2;
    prefix();
    drv_ld(pk(0, 20, 8'h20), 1'b0);
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    for (int i = 0; i <= 20; i++) begin        // c8..c28
      if (i < 20) drv_ld(pk(i, 20, 8'h20), i == 19);
      else        ld_idle();
      if (i == 0) step(8'h00, 1, 0, 0, 0, 1);
      else        step_p(pk(i - 1, 20, 8'h20), 1'b0, i < 20);
    end
    step(8'hBC, 0, 0, 1, 0, 0);                // c29
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 0, 0);                // c33
    step(8'hBC, 0, 0, 1, 0, 0);                // c34 next regular interval
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 0, 0);                // c38

    // 3: OS and LD together at a boundary
    scen = 3;
    prefix();
    drv_os({1'b0, 8'hBC}, 1'b0);
    drv_ld({1'b0, 8'hFB}, 1'b0);
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    step(8'h00, 1, 0, 0, 1, 0);                // c8
    drv_os({1'b1, 8'h4A}, 1'b0);
    step(8'hBC, 0, 0, 0, 1, 0);                // c9 OS COM, no skp_sent
    drv_os({1'b1, 8'h4A}, 1'b1);
    step(8'h4A, 1, 0, 0, 1, 0);                // c10
    os_idle();
    step(8'h4A, 1, 0, 0, 0, 1);                // c11
    drv_ld({1'b1, 8'h55}, 1'b0);
    step(8'hFB, 0, 0, 0, 0, 1);                // c12
    drv_ld({1'b0, 8'hFD}, 1'b1);
    step(8'h55, 1, 0, 0, 0, 1);                // c13
    ld_idle();
    step(8'hFD, 0, 0, 0, 0, 0);                // c14
    step(8'h00, 1, 0, 0, 0, 0);                // c15

    // 4: LD valid gap across an expiry
    scen = 4;
    prefix();
    drv_ld(pk(0, 10, 8'h40), 1'b0);
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    for (int i = 0; i < 7; i++) begin          // c8..c14
      drv_ld(pk(i, 10, 8'h40), 1'b0);
      if (i == 0) step(8'h00, 1, 0, 0, 0, 1);
      else        step_p(pk(i - 1, 10, 8'h40), 1'b0, 1'b1);
    end
    ld_idle();
    step_p(pk(6, 10, 8'h40), 1'b0, 1'b1);      // c15
    step(8'h00, 1, 0, 0, 0, 1);                // c16
    step(8'h00, 1, 0, 0, 0, 1);                // c17
    drv_ld(pk(7, 10, 8'h40), 1'b0);
    step(8'h00, 1, 0, 0, 0, 1);                // c18
    drv_ld(pk(8, 10, 8'h40), 1'b0);
    step_p(pk(7, 10, 8'h40), 1'b0, 1'b1);      // c19
    drv_ld(pk(9, 10, 8'h40), 1'b1);
    step_p(pk(8, 10, 8'h40), 1'b0, 1'b1);      // c20
    ld_idle();
    step_p(pk(9, 10, 8'h40), 1'b0, 1'b0);      // c21
    step(8'hBC, 0, 0, 1, 0, 0);                // c22
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 0, 0);                // c26

    // 5: eidle_req mid-packet, EIOS, EIDLE, exit with SKP before OS data
    scen = 5;
    prefix();
    drv_ld(pk(0, 4, 8'h50), 1'b0);
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    step(8'h00, 1, 0, 0, 0, 1);                // c8
    drv_ld(pk(1, 4, 8'h50), 1'b0);
    eidle_req = 1'b1;
    step(8'hFB, 0, 0, 0, 0, 1);                // c9
    drv_ld(pk(2, 4, 8'h50), 1'b0);
    step(8'h51, 1, 0, 0, 0, 1);                // c10
    drv_ld(pk(3, 4, 8'h50), 1'b1);
    step(8'h52, 1, 0, 0, 0, 1);                // c11
    ld_idle();
    step(8'hFD, 0, 0, 0, 0, 0);                // c12
    step(8'hBC, 0, 0, 0, 0, 0);                // c13 EIOS COM
    step(8'h7C, 0, 0, 0, 0, 0);                // c14
    step(8'h7C, 0, 0, 0, 0, 0);                // c15
    drv_os({1'b0, 8'hBC}, 1'b0);
    step(8'h7C, 0, 0, 0, 0, 0);                // c16
    step(8'h00, 1, 1, 0, 0, 0);                // c17
    eidle_req = 1'b0;
    step(8'h00, 1, 1, 0, 0, 0);                // c18
    step(8'h00, 1, 1, 0, 0, 0);                // c19
    step(8'h00, 1, 0, 0, 0, 0);                // c20
    step(8'hBC, 0, 0, 1, 0, 0);                // c21
    step(8'h1C, 0, 0, 0, 0, 0);                // c22
    step(8'h1C, 0, 0, 0, 0, 0);                // c23
    step(8'h1C, 0, 0, 0, 1, 0);                // c24
    drv_os({1'b1, 8'h4A}, 1'b0);
    step(8'hBC, 0, 0, 0, 1, 0);                // c25
    drv_os({1'b1, 8'h4A}, 1'b1);
    step(8'h4A, 1, 0, 0, 1, 0);                // c26
    os_idle();
    step(8'h4A, 1, 0, 0, 0, 0);                // c27
    step(8'h00, 1, 0, 0, 0, 0);                // c28

    // 6: reset on the second SKP symbol abandons the set
    scen = 6;
    do_reset();
    step(8'h00, 1, 1, 0, 0, 0);                // c0
    step(8'h00, 1, 1, 0, 0, 0);                // c1
    step(8'h00, 1, 0, 0, 0, 0);                // c2
    step(8'hBC, 0, 0, 1, 0, 0);                // c3
    rst = 1'b1;
    step(8'h1C, 0, 0, 0, 0, 0);                // c4
    rst = 1'b0;
    step(8'h00, 1, 1, 0, 0, 0);                // c5 reset values
    step(8'h00, 1, 1, 0, 0, 0);                // c6
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    step(8'hBC, 0, 0, 1, 0, 0);                // c8
    step(8'h1C, 0, 0, 0, 0, 0);                // c9

    // 7: eidle_req dropped during EIOS; EIDLE still lasts one cycle
    scen = 7;
    prefix();
    eidle_req = 1'b1;
    step(8'h00, 1, 0, 0, 0, 0);                // c7
    step(8'h00, 1, 0, 0, 0, 0);                // c8
    eidle_req = 1'b0;
    step(8'hBC, 0, 0, 0, 0, 0);                // c9
    repeat (3) step(8'h7C, 0, 0, 0, 0, 0);     // c10..c12
    step(8'h00, 1, 1, 0, 0, 0);                // c13
    step(8'h00, 1, 0, 0, 0, 0);                // c14
    step(8'hBC, 0, 0, 1, 0, 0);                // c15
    repeat (3) step(8'h1C, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 0, 0);                // c19

    @(negedge clk);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
